// File: rtl/add_result_checker.sv
// add_result_checker: delays each operand vector by LAT cycles and scores the adder DUT's {cout,sum}.
// Optional build macro ADDCHK_HALT_ON_ERR_EN: the first mismatch ends the run (state DONE).
module add_result_checker #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH:0]   fail_exp,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } vec_t;

    localparam logic [2:0] DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

    state_t         r_state;
    state_t         w_next;
    logic [2:0]     r_drain_cnt;
    vec_t           w_push;
    vec_t           w_cmp;
    logic           w_cmp_en;
    logic           w_match;
    logic           w_halt;
    logic [WIDTH:0] w_exp;

    // Vectors are only accepted in RUN; the start and stop edges themselves push a bubble.
    assign w_push.v   = (r_state == S_RUN) && in_valid && !stop && !start;
    assign w_push.a   = a;
    assign w_push.b   = b;
    assign w_push.cin = cin;

    generate
        if (LAT == 0) begin : g_nodelay
            assign w_cmp = w_push;
        end else begin : g_delay
            vec_t r_pipe [LAT];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
                end else if (start || w_halt) begin
                    for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_push;
                    for (int unsigned i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_cmp = r_pipe[LAT-1];
        end
    endgenerate

    assign w_cmp_en = w_cmp.v && !start && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_exp    = {1'b0, w_cmp.a} + {1'b0, w_cmp.b} + {{WIDTH{1'b0}}, w_cmp.cin};
    assign w_match  = ({dut_cout, dut_sum} == w_exp);

`ifdef ADDCHK_HALT_ON_ERR_EN
    assign w_halt = w_cmp_en && !w_match;
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_halt)    w_next = S_DONE;
                    else if (stop) w_next = (LAT == 0) ? S_DONE : S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_halt || (r_drain_cnt == DRAIN_LAST)) w_next = S_DONE;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_RUN) || (r_state == S_DRAIN);
        done = (r_state == S_DONE);
    end

    // Counts DRAIN cycles so DONE arrives exactly LAT edges after stop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   r_drain_cnt <= '0;
        else if (r_state != S_DRAIN) r_drain_cnt <= '0;
        else                         r_drain_cnt <= r_drain_cnt + 3'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || start) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            fail_a   <= '0;
            fail_b   <= '0;
            fail_cin <= 1'b0;
            fail_exp <= '0;
        end else if (w_cmp_en) begin
            if (w_match) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            end else begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                err_flag <= 1'b1;
                if (!err_flag) begin
                    fail_a   <= w_cmp.a;
                    fail_b   <= w_cmp.b;
                    fail_cin <= w_cmp.cin;
                    fail_exp <= w_exp;
                end
            end
        end
    end
endmodule

// File: tb/tb_add_result_checker.sv
// Bench for add_result_checker: three instances (LAT 2/0/3) fed by behavioural adder stand-ins,
// scored against a per-edge log of stimulus replayed through plain arithmetic.
module tb_add_result_checker;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   m;
    } tv_t;

    typedef struct {
        int           pass;
        int           err;
        bit           flag;
        logic [W-1:0] fa;
        logic [W-1:0] fb;
        logic         fc;
        logic [W:0]   fe;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W:0]   fmask = '0;

    always #5 clock = ~clock;

    tv_t lg [4096];
    bit  acc_lg [4096];
    tv_t hist [8];
    tv_t cur;
    int  cyc = 0;
    int  seg_start = 0;
    int  d0 = 2;
    bit  tb_run = 1'b0;
    int  n_total = 0;
    int  n_bad = 0;

    assign cur = {a, b, cin, fmask};

    function automatic logic [W:0] add_ref(tv_t v);
        return {1'b0, v.a} + {1'b0, v.b} + {{W{1'b0}}, v.cin};
    endfunction

    function automatic logic [W:0] resp(tv_t v);
        return add_ref(v) ^ v.m;
    endfunction

    always @(posedge clock) begin
        lg[cyc]     <= cur;
        acc_lg[cyc] <= tb_run && in_valid;
        hist[0]     <= cur;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
        cyc <= cyc + 1;
    end

    // Stand-in adder DUTs; instance 0 has a runtime-adjustable latency.
    logic [W:0] r0, r1, r2;
    assign r0 = (d0 == 0) ? resp(cur) : resp(hist[(d0 > 0) ? d0 - 1 : 0]);
    assign r1 = resp(cur);
    assign r2 = resp(hist[2]);

    logic [15:0]  pc0, ec0, pc2, ec2;
    logic [3:0]   pc1, ec1;
    logic         ef0, ef1, ef2, fc0, fc1, fc2;
    logic [W-1:0] fa0, fa1, fa2, fb0, fb1, fb2;
    logic [W:0]   fe0, fe1, fe2;
    logic         bz0, bz1, bz2, dn0, dn1, dn2;

    add_result_checker #(.WIDTH(W), .LAT(2), .CNT_W(16)) u0 (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .dut_sum(r0[W-1:0]), .dut_cout(r0[W]),
        .pass_cnt(pc0), .err_cnt(ec0), .err_flag(ef0), .fail_a(fa0), .fail_b(fb0),
        .fail_cin(fc0), .fail_exp(fe0), .busy(bz0), .done(dn0));

    add_result_checker #(.WIDTH(W), .LAT(0), .CNT_W(4)) u1 (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .dut_sum(r1[W-1:0]), .dut_cout(r1[W]),
        .pass_cnt(pc1), .err_cnt(ec1), .err_flag(ef1), .fail_a(fa1), .fail_b(fb1),
        .fail_cin(fc1), .fail_exp(fe1), .busy(bz1), .done(dn1));

    add_result_checker #(.WIDTH(W), .LAT(3), .CNT_W(16)) u2 (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .dut_sum(r2[W-1:0]), .dut_cout(r2[W]),
        .pass_cnt(pc2), .err_cnt(ec2), .err_flag(ef2), .fail_a(fa2), .fail_b(fb2),
        .fail_cin(fc2), .fail_exp(fe2), .busy(bz2), .done(dn2));

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Replays every accepted vector since the last start against the stand-in's response.
    function automatic exp_t model(int lat, int dly, int cw);
        exp_t e;
        int   sat;
        e   = '{default: 0};
        sat = (1 << cw) - 1;
        for (int i = seg_start; i < cyc; i++) begin
            if (acc_lg[i]) begin
                tv_t v;
                tv_t r;
                v = lg[i];
                r = lg[i + lat - dly];
                if (resp(r) == add_ref(v)) begin
                    if (e.pass < sat) e.pass++;
                end else begin
                    if (!e.flag) begin
                        e.fa = v.a;
                        e.fb = v.b;
                        e.fc = v.cin;
                        e.fe = add_ref(v);
                    end
                    e.flag = 1'b1;
                    if (e.err < sat) e.err++;
`ifdef ADDCHK_HALT_ON_ERR_EN
                    break;
`endif
                end
            end
        end
        return e;
    endfunction

    task automatic get_out(input int k, output logic [15:0] pc, output logic [15:0] ec,
                           output logic ef, output logic [W-1:0] fa, output logic [W-1:0] fb,
                           output logic fc, output logic [W:0] fe, output logic bz, output logic dn);
        case (k)
            0: begin pc = pc0; ec = ec0; ef = ef0; fa = fa0; fb = fb0; fc = fc0; fe = fe0; bz = bz0; dn = dn0; end
            1: begin pc = {12'b0, pc1}; ec = {12'b0, ec1}; ef = ef1; fa = fa1; fb = fb1; fc = fc1; fe = fe1; bz = bz1; dn = dn1; end
            default: begin pc = pc2; ec = ec2; ef = ef2; fa = fa2; fb = fb2; fc = fc2; fe = fe2; bz = bz2; dn = dn2; end
        endcase
    endtask

    task automatic check_inst(input int k, input string sc);
        logic [15:0]  pc, ec;
        logic [W-1:0] fa, fb;
        logic [W:0]   fe;
        logic         ef, fc, bz, dn;
        exp_t         e;
        int           lat, dly, cw;
        lat = (k == 0) ? 2 : (k == 1) ? 0 : 3;
        dly = (k == 0) ? d0 : lat;
        cw  = (k == 1) ? 4 : 16;
        e   = model(lat, dly, cw);
        get_out(k, pc, ec, ef, fa, fb, fc, fe, bz, dn);
        check_val($sformatf("%s_u%0d_pass", sc, k), 32'(pc), 32'(e.pass));
        check_val($sformatf("%s_u%0d_err", sc, k), 32'(ec), 32'(e.err));
        check_val($sformatf("%s_u%0d_flag", sc, k), 32'(ef), 32'(e.flag));
        check_val($sformatf("%s_u%0d_fa", sc, k), 32'(fa), 32'(e.fa));
        check_val($sformatf("%s_u%0d_fb", sc, k), 32'(fb), 32'(e.fb));
        check_val($sformatf("%s_u%0d_fc", sc, k), 32'(fc), 32'(e.fc));
        check_val($sformatf("%s_u%0d_fe", sc, k), 32'(fe), 32'(e.fe));
        check_val($sformatf("%s_u%0d_done", sc, k), 32'(dn), 32'd1);
        check_val($sformatf("%s_u%0d_busy", sc, k), 32'(bz), 32'd0);
    endtask

    task automatic check_zero(input string sc);
        logic [15:0]  pc, ec;
        logic [W-1:0] fa, fb;
        logic [W:0]   fe;
        logic         ef, fc, bz, dn;
        for (int k = 0; k < 3; k++) begin
            get_out(k, pc, ec, ef, fa, fb, fc, fe, bz, dn);
            check_val($sformatf("%s_u%0d_all", sc, k), {pc, ec},  32'd0);
            check_val($sformatf("%s_u%0d_flags", sc, k), {26'd0, ef, fc, bz, dn, 2'b00}, 32'd0);
            check_val($sformatf("%s_u%0d_fail", sc, k), 32'(fa) | 32'(fb) | 32'(fe), 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic tv_t rvec(logic [W:0] m);
        tv_t v;
        v.a   = W'($urandom);
        v.b   = W'($urandom);
        v.cin = 1'($urandom);
        v.m   = m;
        return v;
    endfunction

    task automatic send(input tv_t v, input bit valid);
        {a, b, cin, fmask} = v;
        in_valid = valid;
        tick();
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start     = 1'b0;
        seg_start = cyc;
        tb_run    = 1'b1;
    endtask

    task automatic do_stop(input bit iv);
        tb_run   = 1'b0;
        stop     = 1'b1;
        in_valid = iv;
        {a, b, cin, fmask} = rvec('0);
        tick();
        stop     = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) send(rvec('0), 1'b0);
    endtask

    task automatic check_all(input string sc);
        for (int k = 0; k < 3; k++) check_inst(k, sc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        check_zero("rst");
        reset = 1'b0;
        idle(2);

        // Single wrap-around vector: 0xFFFF + 1 produces carry out only.
        do_start();
        send({16'hFFFF, 16'h0001, 1'b0, 17'h0}, 1'b1);
        do_stop(1'b0);
        idle(6);
        check_all("one");
        check_val("one_u1_pass_const", 32'(pc1), 32'd1);

        do_start();
        repeat (4) send({16'h1234, 16'h1111, 1'b1, 17'h0}, 1'b1);
        do_stop(1'b0);
        idle(6);
        check_all("rep4");
        check_val("rep4_u0_pass_const", 32'(pc0), 32'd4);

        // Instance 0's stand-in answers one cycle early.
        d0 = 1;
        do_start();
        repeat (8) send(rvec('0), 1'b1);
        do_stop(1'b0);
        idle(6);
        check_all("skew");
        d0 = 2;
        idle(2);

        do_start();
        send(rvec('0), 1'b1);
        send(rvec('0), 1'b1);
        send({16'h00FF, 16'h0001, 1'b0, 17'h00100}, 1'b1);
        send(rvec('0), 1'b0);
        send(rvec('0), 1'b1);
        send(rvec(17'h00003), 1'b1);
        send(rvec('0), 1'b1);
        do_stop(1'b0);
        idle(6);
        check_all("fault");
        check_val("fault_u0_fa_const", 32'(fa0), 32'h00FF);
        check_val("fault_u0_fe_const", 32'(fe0), 32'h00100);

        do_start();
        repeat (20) send(rvec('0), 1'b1);
        do_stop(1'b0);
        idle(6);
        check_all("sat");
        check_val("sat_u1_pass_const", 32'(pc1), 32'd15);

        // Drain timing: done rises LAT edges after stop; DRAIN-time in_valid is ignored.
        do_start();
        repeat (5) send(rvec('0), 1'b1);
        do_stop(1'b1);
        for (int j = 0; j < 5; j++) begin
            check_val($sformatf("drain%0d_u0_done", j), 32'(dn0), 32'(j >= 2));
            check_val($sformatf("drain%0d_u1_done", j), 32'(dn1), 32'd1);
            check_val($sformatf("drain%0d_u2_done", j), 32'(dn2), 32'(j >= 3));
            check_val($sformatf("drain%0d_u2_busy", j), 32'(bz2), 32'(j < 3));
            send(rvec('0), 1'b1);
        end
        in_valid = 1'b0;
        idle(2);
        check_all("drain");
        check_val("drain_u2_pass_const", 32'(pc2), 32'd5);
        do_start();
        check_val("restart_u2_pass", 32'(pc2), 32'd0);
        check_val("restart_u2_busy", 32'(bz2), 32'd1);

        // Asynchronous reset with vectors in flight.
        send(rvec('0), 1'b1);
        send(rvec('0), 1'b1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero("arst");
        tick();
        tick();
        reset = 1'b0;
        tb_run = 1'b0;
        repeat (4) send(rvec('0), 1'b1);
        in_valid = 1'b0;
        idle(3);
        check_zero("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
